instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// instr_fetch_unit: owns the PC, fetches from a synchronous ROM and hands words to the control unit via run/Din/Done.
// Optional issue watchdog (err output) is built when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 9,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] Din,
  output logic              run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT     = 3'd2,
    IMM_REQ  = 3'd3,
    IMM_WAIT = 3'd4,
    ISSUE    = 3'd5
  } state_t;

  localparam logic [1:0]        CNT_INIT = 2'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, next_state;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] instr_reg, imm_reg, din_hold, issue_word;
  logic              first_issue, wait_last, is_mvi, timeout_hit, err_q;

  assign wait_last  = (wait_cnt == 2'd0);
  assign is_mvi     = (instr_reg[DATA_W-1:DATA_W-3] == 3'b001);
  // The mvi opcode word is shown for exactly one cycle before its immediate.
  assign issue_word = (first_issue || !is_mvi) ? instr_reg : imm_reg;

  assign Din      = (state == ISSUE) ? issue_word : din_hold;
  assign run      = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign mem_rd   = (state == REQ) || (state == IMM_REQ);
  assign mem_addr = mem_rd ? pc : '0;
  assign err      = err_q;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start && !halted && !err_q) next_state = REQ;
      REQ:      next_state = WAIT;
      WAIT: begin
        if (wait_last) begin
          if (mem_data[DATA_W-1])                          next_state = IDLE;
          else if (mem_data[DATA_W-2:DATA_W-3] == 2'b01)  next_state = IMM_REQ;
          else                                             next_state = ISSUE;
        end
      end
      IMM_REQ:  next_state = IMM_WAIT;
      IMM_WAIT: if (wait_last) next_state = ISSUE;
      ISSUE: begin
        if (Done)             next_state = start ? REQ : IDLE;
        else if (timeout_hit) next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      pc          <= '0;
      wait_cnt    <= 2'd0;
      instr_reg   <= '0;
      imm_reg     <= '0;
      din_hold    <= '0;
      halted      <= 1'b0;
      first_issue <= 1'b0;
    end else begin
      state       <= next_state;
      first_issue <= (next_state == ISSUE) && (state != ISSUE);
      if (mem_rd) begin
        pc       <= pc + PC_ONE;
        wait_cnt <= CNT_INIT;
      end else if ((state == WAIT || state == IMM_WAIT) && !wait_last) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (state == WAIT && wait_last) begin
        instr_reg <= mem_data;
        if (mem_data[DATA_W-1]) halted <= 1'b1;
      end
      if (state == IMM_WAIT && wait_last) imm_reg <= mem_data;
      if (state == IDLE && !start) halted <= 1'b0;
      if (state == ISSUE) din_hold <= issue_word;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wdog;

  // Fifteenth consecutive ISSUE cycle without Done trips the watchdog.
  assign timeout_hit = (state == ISSUE) && !Done && (wdog == 4'd14);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog  <= 4'd0;
      err_q <= 1'b0;
    end else begin
      if (state != ISSUE)  wdog <= 4'd0;
      else if (!Done)      wdog <= wdog + 4'd1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit: scoreboard bench; ROM reads and Done-cycle Din words are queued as expected and popped as they appear.
module tb_instr_fetch_unit;
  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       resetn, start, Done;
  logic [4:0] mem_addr, pc;
  logic       mem_rd, run, halted, busy, err;
  logic [8:0] mem_data, Din;

  logic [8:0] rom [0:31];
  logic [8:0] rom_pipe [0:LAT-1];
  logic [4:0] exp_addr [$];
  logic [8:0] exp_din [$];
  int total = 0, bad = 0;
  int done_mode = 0, issue_cnt = 0;

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(9), .MEM_LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .Din(Din), .run(run), .Done(Done), .pc(pc), .halted(halted),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM; garbage (a halt opcode) appears when no read was issued.
  always @(posedge clk) begin
    rom_pipe[0] <= mem_rd ? rom[mem_addr] : 9'h1FF;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign mem_data = rom_pipe[LAT-1];

  task automatic tick();
    logic [4:0] ea;
    logic [8:0] ed;
    @(negedge clk);
    if (resetn && mem_rd) begin
      total++;
      if (exp_addr.size() == 0) begin
        bad++; $display("FAIL sb_addr: unexpected read of addr %0d", mem_addr);
      end else begin
        ea = exp_addr.pop_front();
        if (mem_addr !== ea) begin bad++; $display("FAIL sb_addr: got %0d want %0d", mem_addr, ea); end
      end
    end
    if (run) begin
      issue_cnt++;
      Done = (done_mode != 0) && (issue_cnt == done_mode);
    end else begin
      issue_cnt = 0;
      Done = 1'b0;
    end
    if (resetn && Done) begin
      total++;
      if (exp_din.size() == 0) begin
        bad++; $display("FAIL sb_din: unexpected issue Din=%h", Din);
      end else begin
        ed = exp_din.pop_front();
        if (Din !== ed) begin bad++; $display("FAIL sb_din: got %h want %h", Din, ed); end
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; start = 1'b0; done_mode = 0;
    exp_addr.delete(); exp_din.delete();
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic wait_halt(input int limit, input string tag);
    for (int i = 0; i < limit && !halted; i++) tick();
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL %s_halt_wait: halted=%b want 1", tag, halted); end
    total++;
    if (exp_addr.size() != 0 || exp_din.size() != 0) begin
      bad++; $display("FAIL %s_sb_left: addr=%0d din=%0d want 0 0", tag, exp_addr.size(), exp_din.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    total++;
    if ({run, mem_rd, busy, halted, err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: run/rd/busy/halt/err=%b want 00000", {run, mem_rd, busy, halted, err});
    end
    total++;
    if (pc !== 5'd0 || Din !== 9'd0 || mem_addr !== 5'd0) begin
      bad++; $display("FAIL reset_regs: pc=%0d Din=%h addr=%0d want 0 0 0", pc, Din, mem_addr);
    end
  endtask

  task automatic test_mv();
    do_reset();
    rom[0] = 9'h00A; rom[1] = 9'h1C0;
    done_mode = 2;
    exp_addr.push_back(5'd0); exp_addr.push_back(5'd1);
    exp_din.push_back(9'h00A);
    start = 1'b1;
    tick();
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'd0) begin bad++; $display("FAIL mv_req: rd=%b addr=%0d want 1 0", mem_rd, mem_addr); end
    tick();
    total++;
    if (run !== 1'b0) begin bad++; $display("FAIL mv_early_run: run=%b want 0", run); end
    tick();
    total++;
    if (run !== 1'b1 || Din !== 9'h00A) begin bad++; $display("FAIL mv_issue: run=%b Din=%h want 1 00a", run, Din); end
    tick();
    tick();
    total++;
    if (run !== 1'b0 || mem_rd !== 1'b1) begin bad++; $display("FAIL mv_after_done: run=%b rd=%b want 0 1", run, mem_rd); end
    wait_halt(20, "mv");
    total++;
    if (pc !== 5'd2 || busy !== 1'b0 || run !== 1'b0) begin
      bad++; $display("FAIL mv_halted: pc=%0d busy=%b run=%b want 2 0 0", pc, busy, run);
    end
  endtask

  task automatic test_mvi();
    do_reset();
    rom[0] = 9'h058; rom[1] = 9'h1A5; rom[2] = 9'h1C0;
    done_mode = 2;
    exp_addr.push_back(5'd0); exp_addr.push_back(5'd1); exp_addr.push_back(5'd2);
    exp_din.push_back(9'h1A5);
    start = 1'b1;
    repeat (4) tick();
    total++;
    if (run !== 1'b0) begin bad++; $display("FAIL mvi_early_run: run=%b want 0", run); end
    tick();
    total++;
    if (run !== 1'b1 || Din !== 9'h058 || pc !== 5'd2) begin
      bad++; $display("FAIL mvi_first: run=%b Din=%h pc=%0d want 1 058 2", run, Din, pc);
    end
    tick();
    total++;
    if (run !== 1'b1 || Din !== 9'h1A5) begin bad++; $display("FAIL mvi_imm: run=%b Din=%h want 1 1a5", run, Din); end
    wait_halt(20, "mvi");
    total++;
    if (pc !== 5'd3) begin bad++; $display("FAIL mvi_pc: pc=%0d want 3", pc); end
  endtask

  task automatic test_halt_resume();
    do_reset();
    rom[0] = 9'h00A; rom[1] = 9'h0D1; rom[2] = 9'h1C0; rom[3] = 9'h013; rom[4] = 9'h1FF;
    done_mode = 1;
    for (int a = 0; a < 3; a++) exp_addr.push_back(5'(a));
    exp_din.push_back(9'h00A); exp_din.push_back(9'h0D1);
    start = 1'b1;
    wait_halt(40, "halt1");
    repeat (5) tick();
    total++;
    if (pc !== 5'd3 || busy !== 1'b0 || run !== 1'b0) begin
      bad++; $display("FAIL halt_state: pc=%0d busy=%b run=%b want 3 0 0", pc, busy, run);
    end
    start = 1'b0;
    tick();
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL halt_clear: halted=%b want 0", halted); end
    exp_addr.push_back(5'd3); exp_addr.push_back(5'd4);
    exp_din.push_back(9'h013);
    start = 1'b1;
    wait_halt(40, "halt2");
    total++;
    if (pc !== 5'd5) begin bad++; $display("FAIL halt_resume_pc: pc=%0d want 5", pc); end
  endtask

  task automatic test_wrap();
    int i;
    do_reset();
    for (int a = 0; a < 30; a++) rom[a] = 9'h020 + 9'(a);
    rom[30] = 9'h1C0; rom[31] = 9'h00A;
    done_mode = 1;
    for (int a = 0; a < 31; a++) exp_addr.push_back(5'(a));
    for (int a = 0; a < 30; a++) exp_din.push_back(9'h020 + 9'(a));
    start = 1'b1;
    wait_halt(400, "wrap1");
    total++;
    if (pc !== 5'd31) begin bad++; $display("FAIL wrap_pc31: pc=%0d want 31", pc); end
    rom[0] = 9'h1C0;
    exp_addr.push_back(5'd31); exp_addr.push_back(5'd0);
    exp_din.push_back(9'h00A);
    start = 1'b0;
    tick();
    start = 1'b1;
    i = 0;
    do begin tick(); i++; end while (!mem_rd && i < 10);
    tick();
    total++;
    if (pc !== 5'd0) begin bad++; $display("FAIL wrap_pc0: pc=%0d want 0", pc); end
    wait_halt(40, "wrap2");
    total++;
    if (pc !== 5'd1) begin bad++; $display("FAIL wrap_pc1: pc=%0d want 1", pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    rom[0] = 9'h00A; rom[1] = 9'h1C0;
    done_mode = 0;
    exp_addr.push_back(5'd0);
    start = 1'b1;
    for (int k = 0; k < 10 && !run; k++) tick();
    repeat (2) tick();
    total++;
    if (run !== 1'b1) begin bad++; $display("FAIL ar_issue: run=%b want 1", run); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (run !== 1'b0 || pc !== 5'd0 || Din !== 9'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL ar_immediate: run=%b pc=%0d Din=%h busy=%b want 0 0 000 0", run, pc, Din, busy);
    end
    tick();
    exp_addr.delete(); exp_din.delete();
    exp_addr.push_back(5'd0); exp_addr.push_back(5'd1);
    exp_din.push_back(9'h00A);
    done_mode = 1;
    resetn = 1'b1;
    wait_halt(40, "ar");
    total++;
    if (pc !== 5'd2) begin bad++; $display("FAIL ar_pc: pc=%0d want 2", pc); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    do_reset();
    rom[0] = 9'h00A;
    done_mode = 0;
    exp_addr.push_back(5'd0);
    start = 1'b1;
    for (int k = 0; k < 10 && !run; k++) tick();
    cnt = 0;
    while (run && cnt < 40) begin cnt++; tick(); end
    total++;
    if (cnt != 15 || err !== 1'b1 || run !== 1'b0) begin
      bad++; $display("FAIL wd_trip: cycles=%0d err=%b run=%b want 15 1 0", cnt, err, run);
    end
    repeat (10) tick();
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wd_sticky: err=%b busy=%b want 1 0", err, busy); end
    do_reset();
    tick();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL wd_reset: err=%b want 0", err); end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    rom[0] = 9'h00A;
    done_mode = 0;
    exp_addr.push_back(5'd0);
    start = 1'b1;
    for (int k = 0; k < 10 && !run; k++) tick();
    repeat (30) tick();
    total++;
    if (run !== 1'b1 || err !== 1'b0 || Din !== 9'h00A) begin
      bad++; $display("FAIL no_wd_hold: run=%b err=%b Din=%h want 1 0 00a", run, err, Din);
    end
    do_reset();
  endtask
`endif

  initial begin
    resetn = 1'b0; start = 1'b0; Done = 1'b0;
    for (int a = 0; a < 32; a++) rom[a] = 9'h1FF;
    test_reset();
    test_mv();
    test_mvi();
    test_halt_resume();
    test_wrap();
    test_async_reset();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
